remote_arm_sequencer: RTL and testbench
=======================================

# remote_arm_sequencer

Parametrised successor to the single-channel remote initializer. Drives `NUM_CH` RC-remote channel values through a fixed arming sequence (settle, throttle-low/yaw-max arm stick, release), then hands control to the gesture command path with per-channel slew limiting. It sits between the gesture-to-command logic and the DAC/PWM stage that feeds the remote, and aborts to safe values whenever `on_state` drops.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channels.
- `WIDTH`, default 8: bits per channel value.
- `THR_CH`, default 0: throttle channel index.
- `YAW_CH`, default 3: yaw channel index. Must differ from `THR_CH`.
- `HOLD_CYCLES`, default 10: duration of SETTLE and of RELEASE. Must be ≥1.
- `ARM_CYCLES`, default 20: duration of ARM. Must be ≥1.
- `SLEW`, default 4: maximum per-cycle change per channel in READY. A value of 0 means no limit.

Ports (one clock; reset is synchronous and active-high):
- `clock`, input, 1: system clock. All state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `on_state`, input, 1: level request to arm and fly. Low forces abort.
- `cmd_in`, input, NUM_CH*WIDTH: channel commands from the gesture path. Channel k is at bits [k*WIDTH +: WIDTH].
- `ch_out`, output, NUM_CH*WIDTH: registered channel values to the remote. Same packing as `cmd_in`.
- `armed`, output, 1: high while in READY.
- `busy`, output, 1: high in SETTLE, ARM and RELEASE.

## Operation
Value constants:
- MIN = 0
- MAX = 2^WIDTH−1
- MID = 2^(WIDTH−1)

SAFE vector: throttle channel = MIN; every other channel = MID.

States:
- IDLE: `ch_out` = SAFE. If `on_state`=1, go to SETTLE.
- SETTLE: `ch_out` = SAFE. Stays HOLD_CYCLES cycles, then goes to ARM.
- ARM: throttle = MIN, yaw = MAX, other channels = MID. Stays ARM_CYCLES cycles, then goes to RELEASE.
- RELEASE: `ch_out` = SAFE. Stays HOLD_CYCLES cycles, then goes to READY.
- READY: each channel steps toward its `cmd_in` value. Step size = min(SLEW, |cmd − out|), or the full difference when SLEW=0. Arithmetic is unsigned with no overflow, because the step is clamped at the target.

Abort and reset:
- `on_state`=0 sampled in any non-IDLE state: next state is IDLE, `ch_out` snaps to SAFE with no slew, and the dwell timer clears.
- `reset` overrides everything.
- Re-asserting `on_state` always restarts from SETTLE. There is no partial resume.

Dwell timer:
- A single counter, $clog2(max(HOLD_CYCLES, ARM_CYCLES)) bits (minimum 1).
- Cleared on every state change.
- The state exits on the edge where count = duration−1.

A `cmd_in` change during SETTLE, ARM or RELEASE is ignored.

## Timing
- Reset values: state = IDLE, `ch_out` = SAFE, `armed` = 0, `busy` = 0, timer = 0.
- All outputs are registered and reflect the state of the current cycle.
- If edge E samples `on_state`=1 in IDLE:
  - `busy` rises after E.
  - ARM values appear HOLD_CYCLES cycles later.
  - `busy` falls and `armed` rises after edge E + HOLD_CYCLES + ARM_CYCLES + HOLD_CYCLES.
- On entering READY, `ch_out` starts from SAFE. The first slew step appears one cycle after `armed` rises.
- Abort latency: one edge. The cycle after `on_state`=0 is sampled shows SAFE with `armed`=`busy`=0.
- Simultaneous `reset` and `on_state`=1: reset wins. The sequence can start on the following edge.
- `on_state`=0 on the exact edge a dwell would expire: abort wins.

## Structure
- Shared package `remote_pkg` holds:
  - the state enum (IDLE, SETTLE, ARM, RELEASE, READY);
  - MIN/MID/MAX constant functions of WIDTH;
  - a SAFE-vector function taking NUM_CH, WIDTH and THR_CH.
- Sub-module `channel_slew` (one instance per channel via generate):
  - inputs: `clock`, `reset`, `load`, `load_val`, `enable`, `target`;
  - output: `out`;
  - applies the slew rule when `enable` is high;
  - `load` has priority and forces `out` = `load_val`.
- The top-level FSM drives `load` in all non-READY states.

## Test plan
All scenarios use NUM_CH=4, WIDTH=8, HOLD=10, ARM=20, SLEW=4, THR_CH=0, YAW_CH=3 unless noted.

1. **Reset with `on_state`=0:** `ch_out` = {ch3..ch0} = 80,80,80,00 hex, `armed`=0, `busy`=0, held indefinitely.
2. **Full arm:** `on_state`=1 sampled at edge 0.
   - ch3 = FF exactly in cycles 11–30 (after edges 10–29).
   - `armed`=1 after edge 40.
   - `busy` high after edges 0–39.
3. **Slew:** in READY with `cmd_in` ch0 = 13 hex and ch1 = 70 hex.
   - ch0 sequence: 00, 04, 08, 0C, 10, 13, then held.
   - ch1 sequence: 80, 7C, 78, 74, 70, then held.
4. **Abort mid-ARM:** drop `on_state` at cycle 15. The next cycle shows SAFE with `armed`=`busy`=0. Re-asserting `on_state` yields `armed` exactly 40 edges after the re-sample.
5. **Reset in READY** while `on_state` is held high: SAFE with `armed`=0 on the cycle after reset. The sequence restarts, and `armed` returns 41 edges after reset deasserts.
6. **SLEW=0, NUM_CH=6, WIDTH=10:** in READY, `ch_out` equals `cmd_in` one cycle after each change. SAFE has MID = 200 hex.

Source files
------------

// File: rtl/remote_pkg.sv
// remote_pkg: shared definitions for the remote arming sequencer.
//   state_t    - sequencer FSM states
//   min_val    - lowest channel value for a given width
//   mid_val    - centre channel value for a given width
//   max_val    - highest channel value for a given width
//   safe_vec   - packed SAFE vector (throttle MIN, all others MID)
package remote_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ARM     = 3'd2,
      ST_RELEASE = 3'd3,
      ST_READY   = 3'd4
   } state_t;

   // Upper bound on NUM_CH*WIDTH; callers slice the low bits they need.
   localparam int VEC_BITS = 1024;

   function automatic logic [31:0] max_val(int width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

   // All-zero bits of a WIDTH-wide value.
   function automatic logic [31:0] min_val(int width);
      return max_val(width) & 32'h0;
   endfunction

   function automatic logic [31:0] mid_val(int width);
      return 32'd1 << (width - 1);
   endfunction

   function automatic logic [VEC_BITS-1:0] safe_vec(int num_ch, int width, int thr_ch);
      logic [VEC_BITS-1:0] v;
      logic [31:0]         mid;
      logic [31:0]         lo;
      v   = '0;
      mid = mid_val(width);
      lo  = min_val(width);
      for (int k = 0; k < num_ch; k++)
         for (int b = 0; b < width; b++)
            v[k*width + b] = (k == thr_ch) ? lo[b] : mid[b];
      return v;
   endfunction

endpackage

// File: rtl/channel_slew.sv
// channel_slew: one registered channel value with slew-limited tracking.
//   clock, reset - clock and synchronous active-high reset (out <= RST_VAL)
//   load         - priority load, out <= load_val
//   load_val     - value for load
//   enable       - step out toward target by at most SLEW (0 = no limit)
//   target       - commanded value
//   out          - registered channel value
module channel_slew #(
   parameter int                WIDTH   = 8,
   parameter int                SLEW    = 4,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] out
);

   // A slew at least as large as the full range never limits; treat it as 0.
   localparam int               SLEW_CAP = (SLEW > (2**WIDTH - 1)) ? 0 : SLEW;
   localparam logic [WIDTH-1:0] SLEW_V   = WIDTH'(SLEW_CAP);

   logic             up;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] step;

   // Step is clamped at the remaining distance, so out never passes target.
   always_comb begin
      up   = target > out;
      diff = up ? (target - out) : (out - target);
      step = (SLEW_CAP == 0 || diff <= SLEW_V) ? diff : SLEW_V;
   end

   always_ff @(posedge clock) begin
      if (reset)       out <= RST_VAL;
      else if (load)   out <= load_val;
      else if (enable) out <= up ? (out + step) : (out - step);
   end

endmodule

// File: rtl/remote_arm_sequencer.sv
// remote_arm_sequencer: arms an RC remote (settle, arm stick, release) and
// then passes slew-limited gesture commands through to the channels.
//   clock, reset - clock, synchronous active-high reset
//   on_state     - level request to arm and fly; low aborts to SAFE
//   cmd_in       - NUM_CH packed commands, channel k at [k*WIDTH +: WIDTH]
//   ch_out       - registered channel values, same packing
//   armed        - high in READY
//   busy         - high in SETTLE, ARM, RELEASE
module remote_arm_sequencer
   import remote_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = 8,
   parameter int THR_CH      = 0,
   parameter int YAW_CH      = 3,
   parameter int HOLD_CYCLES = 10,
   parameter int ARM_CYCLES  = 20,
   parameter int SLEW        = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    on_state,
   input  logic [NUM_CH*WIDTH-1:0] cmd_in,
   output logic [NUM_CH*WIDTH-1:0] ch_out,
   output logic                    armed,
   output logic                    busy
);

   localparam int VW      = NUM_CH * WIDTH;
   localparam int DUR_MAX = (HOLD_CYCLES > ARM_CYCLES) ? HOLD_CYCLES : ARM_CYCLES;
   localparam int TW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

   localparam logic [VEC_BITS-1:0] SAFE_FULL = safe_vec(NUM_CH, WIDTH, THR_CH);
   localparam logic [VW-1:0]       SAFE_V    = SAFE_FULL[VW-1:0];
   localparam logic [31:0]         MAX_FULL  = max_val(WIDTH);
   localparam logic [WIDTH-1:0]    MAX_V     = MAX_FULL[WIDTH-1:0];
   localparam logic [TW-1:0]       HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]       ARM_LAST  = TW'(ARM_CYCLES - 1);

   state_t                        state, next_state;
   logic [TW-1:0]                 timer;
   logic [VW-1:0]                 load_val;
   logic                          load;
   logic                          enable;
   logic [NUM_CH-1:0][WIDTH-1:0]  ch_q;

   // Abort (on_state low) takes precedence over dwell expiry.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (on_state) next_state = ST_SETTLE;
         ST_SETTLE:  if (!on_state) next_state = ST_IDLE;
                     else if (timer == HOLD_LAST) next_state = ST_ARM;
         ST_ARM:     if (!on_state) next_state = ST_IDLE;
                     else if (timer == ARM_LAST) next_state = ST_RELEASE;
         ST_RELEASE: if (!on_state) next_state = ST_IDLE;
                     else if (timer == HOLD_LAST) next_state = ST_READY;
         ST_READY:   if (!on_state) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Channel values are loaded from the next state so ch_out lines up with
   // the registered state. READY entry also loads SAFE; slewing starts the
   // cycle after.
   always_comb begin
      load_val = SAFE_V;
      if (next_state == ST_ARM) load_val[YAW_CH*WIDTH +: WIDTH] = MAX_V;
   end

   assign load   = (state != ST_READY) || (next_state != ST_READY);
   assign enable = !load;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         timer <= '0;
         armed <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state || state == ST_IDLE || state == ST_READY)
            timer <= '0;
         else
            timer <= timer + TW'(1);
         armed <= (next_state == ST_READY);
         busy  <= (next_state == ST_SETTLE) || (next_state == ST_ARM) ||
                  (next_state == ST_RELEASE);
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      channel_slew #(
         .WIDTH   (WIDTH),
         .SLEW    (SLEW),
         .RST_VAL (SAFE_V[k*WIDTH +: WIDTH])
      ) u_slew (
         .clock    (clock),
         .reset    (reset),
         .load     (load),
         .load_val (load_val[k*WIDTH +: WIDTH]),
         .enable   (enable),
         .target   (cmd_in[k*WIDTH +: WIDTH]),
         .out      (ch_q[k])
      );
   end

   assign ch_out = ch_q;

endmodule

// File: tb/tb_remote_arm_sequencer.sv
module tb_remote_arm_sequencer;

   logic        clock = 1'b0;
   logic        reset, on_state, on6;
   logic [31:0] cmd_in, ch_out;
   logic        armed, busy;
   logic [59:0] cmd6, ch_out6;
   logic        armed6, busy6;

   always #5 clock = ~clock;

   remote_arm_sequencer dut (
      .clock(clock), .reset(reset), .on_state(on_state), .cmd_in(cmd_in),
      .ch_out(ch_out), .armed(armed), .busy(busy));

   remote_arm_sequencer #(.NUM_CH(6), .WIDTH(10), .SLEW(0)) dut6 (
      .clock(clock), .reset(reset), .on_state(on6), .cmd_in(cmd6),
      .ch_out(ch_out6), .armed(armed6), .busy(busy6));

   localparam logic [31:0] SAFE4 = 32'h8080_8000;
   localparam logic [31:0] ARM4  = 32'hFF80_8000;
   localparam logic [59:0] SAFE6 = 60'h802008020080000;

   typedef struct {
      int          cyc;
      bit          sel;
      logic [63:0] val;
      logic        arm;
      logic        bsy;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   ecount = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   base;

   always @(posedge clock) ecount <= ecount + 1;

   task automatic push(input int after_edge, input bit sel, input logic [63:0] val,
                       input logic a, input logic b, input string nm);
      exp_t e;
      e.cyc = base + after_edge + 1;
      e.sel = sel; e.val = val; e.arm = a; e.bsy = b; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clock);
   endtask

   always @(negedge clock) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == ecount) begin
            logic [63:0] av;
            logic        aa, ab;
            if (sb[i].sel) begin av = {4'h0, ch_out6}; aa = armed6; ab = busy6; end
            else           begin av = {32'h0, ch_out}; aa = armed;  ab = busy;  end
            n_cmp++;
            if (av !== sb[i].val || aa !== sb[i].arm || ab !== sb[i].bsy) begin
               n_bad++;
               $display("FAIL %s cyc %0d: got ch=%h armed=%b busy=%b, want ch=%h armed=%b busy=%b",
                        sb[i].nm, ecount, av, aa, ab, sb[i].val, sb[i].arm, sb[i].bsy);
            end
            sb.delete(i);
         end
      end
   end

   logic [7:0] slew0 [7] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h13, 8'h13, 8'h13};
   logic [7:0] slew1 [7] = '{8'h7C, 8'h78, 8'h74, 8'h70, 8'h70, 8'h70, 8'h70};
   logic [59:0] vec6 [5] = '{60'h0, 60'hFFFFFFFFFFFFFFF, 60'h123456789ABCDEF,
                             60'h3FF00000000FFC0, 60'h200200200200200};

   initial begin
      reset = 1'b1; on_state = 1'b0; on6 = 1'b0;
      cmd_in = SAFE4; cmd6 = SAFE6;

      @(negedge clock); base = ecount;
      n_cmp++;
      if (ch_out !== SAFE4 || armed !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_direct: ch=%h armed=%b busy=%b", ch_out, armed, busy);
      end
      n_cmp++;
      if (ch_out6 !== SAFE6 || armed6 !== 1'b0 || busy6 !== 1'b0) begin
         n_bad++;
         $display("FAIL rst6_direct: ch=%h armed=%b busy=%b", ch_out6, armed6, busy6);
      end
      push(0, 0, {32'h0, SAFE4}, 0, 0, "rst");
      push(0, 1, {4'h0, SAFE6}, 0, 0, "rst6");
      wait_neg(2);
      reset = 1'b0; base = ecount;
      for (int j = 0; j < 5; j++) begin
         push(j, 0, {32'h0, SAFE4}, 0, 0, "idle");
         push(j, 1, {4'h0, SAFE6}, 0, 0, "idle6");
      end
      wait_neg(6);
      n_cmp++;
      if (ch_out !== SAFE4 || armed !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_direct: ch=%h armed=%b busy=%b", ch_out, armed, busy);
      end
      n_cmp++;
      if (ch_out6 !== SAFE6 || armed6 !== 1'b0 || busy6 !== 1'b0) begin
         n_bad++;
         $display("FAIL idle6_direct: ch=%h armed=%b busy=%b", ch_out6, armed6, busy6);
      end

      cmd_in = 32'h1234_5678; on_state = 1'b1; base = ecount;
      for (int j = 0; j < 40; j++)
         push(j, 0, {32'h0, (j >= 10 && j <= 29) ? ARM4 : SAFE4}, 0, 1, "arm_seq");
      push(40, 0, {32'h0, SAFE4}, 1, 0, "ready_entry");
      for (int j = 0; j < 7; j++)
         push(41 + j, 0, {32'h0, 16'h8080, slew1[j], slew0[j]}, 1, 0, "slew");
      wait_neg(20);
      cmd_in = 32'h8080_7013;
      wait_neg(30);

      on_state = 1'b0; base = ecount;
      push(0, 0, {32'h0, SAFE4}, 0, 0, "abort_ready");
      push(1, 0, {32'h0, SAFE4}, 0, 0, "abort_idle");
      wait_neg(3);

      on_state = 1'b1; base = ecount;
      push(14, 0, {32'h0, ARM4}, 0, 1, "pre_abort");
      push(15, 0, {32'h0, SAFE4}, 0, 0, "abort_arm");
      push(16, 0, {32'h0, SAFE4}, 0, 0, "abort_arm_hold");
      wait_neg(15);
      on_state = 1'b0;
      wait_neg(3);
      on_state = 1'b1; base = ecount;
      push(39, 0, {32'h0, SAFE4}, 0, 1, "rearm_39");
      push(40, 0, {32'h0, SAFE4}, 1, 0, "rearm_40");
      push(41, 0, {32'h0, 32'h8080_7C04}, 1, 0, "rearm_step");
      wait_neg(45);

      on_state = 1'b0; wait_neg(3);
      on_state = 1'b1; base = ecount;
      push(9, 0, {32'h0, SAFE4}, 0, 1, "settle_last");
      push(10, 0, {32'h0, SAFE4}, 0, 0, "abort_expiry");
      push(11, 0, {32'h0, SAFE4}, 0, 0, "abort_expiry_idle");
      wait_neg(10);
      on_state = 1'b0;
      wait_neg(3);

      on_state = 1'b1; wait_neg(50);
      reset = 1'b1; base = ecount;
      push(0, 0, {32'h0, SAFE4}, 0, 0, "rst_ready");
      push(1, 0, {32'h0, SAFE4}, 0, 1, "rst_restart");
      push(40, 0, {32'h0, SAFE4}, 0, 1, "rst_40");
      push(41, 0, {32'h0, SAFE4}, 1, 0, "rst_41");
      push(42, 0, {32'h0, 32'h8080_7C04}, 1, 0, "rst_step");
      wait_neg(1);
      reset = 1'b0;
      wait_neg(45);

      on6 = 1'b1; base = ecount;
      push(0, 1, {4'h0, SAFE6}, 0, 1, "w6_settle");
      push(40, 1, {4'h0, SAFE6}, 1, 0, "w6_ready");
      push(41, 1, {4'h0, SAFE6}, 1, 0, "w6_hold");
      wait_neg(42);
      for (int i = 0; i < 5; i++) begin
         cmd6 = vec6[i]; base = ecount;
         push(0, 1, {4'h0, vec6[i]}, 1, 0, "w6_track");
         wait_neg(1);
      end
      wait_neg(3);

      while (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: never checked, due cyc %0d now %0d", sb[0].nm, sb[0].cyc, ecount);
         void'(sb.pop_front());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
